rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Owns the single register-file write port. After reset, sequences a one-register-per-cycle
//  clear of x1..x(NUM_REGS-1) while holding the pipeline. Then shares the port between
//  pipeline writeback (WB, priority) and a debug/loader requester (valid/ready). Sits between
//  the WB stage and Register_File; drives its RdW/ResultW/RegWriteW inputs.
// PARAMETERS
//  XLEN        32  data width
//  NUM_REGS    32  architectural registers; address width AW = $clog2(NUM_REGS)
//  CLEAR_VAL   0   value written to every register during the clear sequence
//  STARVE_MAX  8   debug wait cycles before forced grant (used only with RF_DBG_STARVE_GUARD_EN)
// PORTS
//  clk         in   1     clock; all state updates on posedge
//  rst         in   1     synchronous, active-high reset
//  wb_we       in   1     WB write request
//  wb_rd       in   AW    WB destination register
//  wb_data     in   XLEN  WB write data
//  dbg_valid   in   1     debug write request
//  dbg_addr    in   AW    debug destination register
//  dbg_data    in   XLEN  debug write data
//  dbg_ready   out  1     debug write accepted this cycle when dbg_valid && dbg_ready
//  rf_we       out  1     register-file write enable
//  rf_wa       out  AW    register-file write address
//  rf_wd       out  XLEN  register-file write data
//  pipe_stall  out  1     freeze all pipeline registers, MEM/WB included
//  init_done   out  1     clear sequence complete
// BEHAVIOUR
//  State: registered FSM {CLEAR, RUN} plus clr_idx[AW-1:0].
//  Port outputs: combinational from state and inputs; a WB write reaches rf_* in its own cycle (0 latency).
//  Reset (rst=1 at posedge): state<=CLEAR, clr_idx<=1, starve_cnt<=0.
//   - Applies at any time, including mid-clear or mid-RUN. Pending debug requests are not remembered.
//  CLEAR:
//   - rf_we=1, rf_wa=clr_idx, rf_wd=CLEAR_VAL.
//   - pipe_stall=1, dbg_ready=0, init_done=0.
//   - wb_* ignored.
//   - clr_idx increments each cycle; at clr_idx==NUM_REGS-1, next state=RUN.
//   - Total NUM_REGS-1 cycles (31 by default). x0 is never written.
//  RUN: init_done=1, pipe_stall=0 (except forced grant below). Priority order:
//   1. wb_we && wb_rd!=0: rf_we=1, rf_wa=wb_rd, rf_wd=wb_data, dbg_ready=0.
//   2. Otherwise, if dbg_valid && dbg_addr!=0: rf_we=1 with dbg_addr/dbg_data, dbg_ready=1.
//   3. Otherwise: rf_we=0, rf_wa=0, rf_wd=0.
//  x0 filtering:
//   - WB write to x0 does not count as a WB write, so a debug write may take the port that cycle.
//   - Debug write to x0: dbg_ready=1, rf_we=0 (accepted and dropped).
//  Same-address WB and debug in one cycle: WB wins; debug retries (no merge).
//  dbg_ready=0 whenever dbg_valid=0 (no idle-ready).
//  Outputs during rst=1: follow current state. After the reset edge, CLEAR values appear.
// CONFIGURATION
//  RF_DBG_STARVE_GUARD_EN defined:
//   - starve_cnt counts RUN cycles with dbg_valid && !dbg_ready, saturating at STARVE_MAX.
//   - When starve_cnt==STARVE_MAX: pipe_stall=1 and the debug write is granted over WB that cycle.
//   - The held WB write is re-presented next cycle.
//   - starve_cnt clears on a debug handshake, on !dbg_valid, or on reset.
//  Undefined: no starve_cnt; WB always wins; pipe_stall=0 in RUN; STARVE_MAX unused.
// STRUCTURE
//  Shared package rf_pkg:
//   - localparams XLEN, NUM_REGS, AW
//   - typedef arb_state_e {CLEAR, RUN}
//   - typedef rf_wr_t {we, addr, data}, reused by WB-stage and debug logic
//  Sub-module rf_clear_seq: the clr_idx counter and done flag.
//  Grant mux and starvation guard stay in the top module.
// TESTING
//  1. rst high 1 cycle, then low -> rf_we=1 with rf_wa=1..31 on consecutive cycles,
//     pipe_stall=1 for 31 cycles; init_done=1 on cycle 32.
//  2. RUN, wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, dbg_valid=1 same cycle
//     -> rf_wa=5, rf_wd=0xDEADBEEF, dbg_ready=0; next cycle with wb_we=0 -> debug granted.
//  3. RUN, wb_we=1, wb_rd=0, dbg_valid=1, dbg_addr=7, dbg_data=0x12
//     -> rf_we=1, rf_wa=7, rf_wd=0x12, dbg_ready=1.
//  4. dbg_valid=1, dbg_addr=0 -> dbg_ready=1, rf_we=0.
//  5. rst asserted when clr_idx=12 -> next cycle rf_wa=1; full 31-cycle clear repeats.
//  6. [GUARD_EN] wb_we=1 (rd=3) every cycle and dbg_valid held -> after 8 cycles, pipe_stall=1
//     and the debug write is granted; the WB write to x3 lands the following cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg
// Shared definitions for the register-file write-port slice: data and
// address widths, the arbiter state type and the write-request record
// used by both the WB-stage and debug/loader paths.
package rf_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int AW       = $clog2(NUM_REGS);

  // CLEAR walks x1..x(NUM_REGS-1) after reset; RUN arbitrates WB vs debug.
  typedef enum logic {
    CLEAR,
    RUN
  } arb_state_e;

  // One register-file write: enable, destination and data.
  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq
// Post-reset clear sequencer. Holds the arbiter state and the register
// index being cleared; steps through x1..x(NUM_REGS-1), one per cycle,
// then parks in RUN until the next reset.
// Ports:
//   clk      in   clock, all updates on posedge
//   rst      in   synchronous active-high reset, restarts the sequence
//   state    out  current arbiter state (CLEAR or RUN)
//   clr_idx  out  register index to clear this cycle (valid in CLEAR)
//   done     out  high once the clear sequence has finished
module rf_clear_seq
  import rf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  output arb_state_e    state,
  output logic [AW-1:0] clr_idx,
  output logic          done
);

  // Reset always restarts at x1 so x0 is never written. The last index
  // is cleared in its own cycle and the following cycle is already RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
    end else if (state == CLEAR) begin
      if (clr_idx == AW'(NUM_REGS - 1)) begin
        state   <= RUN;
        clr_idx <= '0;
      end else begin
        clr_idx <= clr_idx + AW'(1);
      end
    end
  end

  assign done = (state == RUN);

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Owns the single register-file write port. After reset it clears
// x1..x(NUM_REGS-1) while stalling the pipeline, then shares the port
// between WB writeback (priority) and a debug/loader valid/ready requester.
// Writes to x0 are filtered from both sources. Port outputs are
// combinational, so a WB write reaches rf_* in its own cycle.
// Optional feature: define RF_DBG_STARVE_GUARD_EN to add a starvation
// guard that forces a debug grant (with pipe_stall) after STARVE_MAX
// consecutive denied debug cycles.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   wb_we/wb_rd/wb_data   WB write request
//   dbg_valid/dbg_addr/dbg_data, dbg_ready   debug write handshake
//   rf_we/rf_wa/rf_wd     register-file write port
//   pipe_stall            freezes all pipeline registers
//   init_done             clear sequence complete
module rf_write_arbiter
  import rf_pkg::*;
#(
`ifdef RF_DBG_STARVE_GUARD_EN
  parameter int              STARVE_MAX = 8,
`endif
  parameter logic [XLEN-1:0] CLEAR_VAL  = '0
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            dbg_valid,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_data,
  output logic            dbg_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            pipe_stall,
  output logic            init_done
);

  arb_state_e    state;
  logic [AW-1:0] clr_idx;
  logic          force_dbg;
  rf_wr_t        wb_req;
  rf_wr_t        dbg_req;
  rf_wr_t        wr;

  rf_clear_seq u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .state   (state),
    .clr_idx (clr_idx),
    .done    (init_done)
  );

  // A write to x0 is not a real write: its enable is dropped here so that
  // a WB x0 write does not block debug, and a debug x0 write is accepted
  // but never reaches the register file.
  assign wb_req  = '{we: wb_we && (wb_rd != '0),        addr: wb_rd,    data: wb_data};
  assign dbg_req = '{we: dbg_valid && (dbg_addr != '0), addr: dbg_addr, data: dbg_data};

`ifdef RF_DBG_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  // Counts consecutive RUN cycles where debug waits; saturates so the
  // forced grant is held until the handshake clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state != RUN || !dbg_valid || dbg_ready) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign force_dbg = (state == RUN) && dbg_valid && (starve_cnt == SW'(STARVE_MAX));
`else
  assign force_dbg = 1'b0;
`endif

  // Port mux. A forced debug grant stalls the pipeline so the displaced
  // WB write is simply re-presented by the frozen MEM/WB stage next cycle.
  always_comb begin
    wr         = '0;
    dbg_ready  = 1'b0;
    pipe_stall = 1'b0;
    if (state == CLEAR) begin
      wr         = '{we: 1'b1, addr: clr_idx, data: CLEAR_VAL};
      pipe_stall = 1'b1;
    end else if (force_dbg) begin
      pipe_stall = 1'b1;
      dbg_ready  = 1'b1;
      if (dbg_req.we) wr = dbg_req;
    end else if (wb_req.we) begin
      wr = wb_req;
    end else if (dbg_valid) begin
      dbg_ready = 1'b1;
      if (dbg_req.we) wr = dbg_req;
    end
  end

  assign rf_we = wr.we;
  assign rf_wa = wr.addr;
  assign rf_wd = wr.data;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
// Directed bench for rf_write_arbiter. Stimulus drives one cycle at a
// time and queues the hand-computed port values for that cycle; a
// monitor on the falling edge pops and compares them.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wb_we = 1'b0;
  logic [AW-1:0]   wb_rd = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            dbg_valid = 1'b0;
  logic [AW-1:0]   dbg_addr = '0;
  logic [XLEN-1:0] dbg_data = '0;
  logic            dbg_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic            pipe_stall;
  logic            init_done;

  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            rdy;
    logic            stall;
    logic            done;
    string           tag;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  rf_write_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .dbg_valid  (dbg_valid),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .dbg_ready  (dbg_ready),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .pipe_stall (pipe_stall),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                              input logic rdy, input logic stall, input logic done, input string tag);
    exp_t e;
    e.we = we; e.wa = wa; e.wd = wd; e.rdy = rdy; e.stall = stall; e.done = done; e.tag = tag;
    return e;
  endfunction

  // Drive one cycle of inputs just after the clock edge and queue what
  // the outputs must show during that cycle.
  task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] rd,
                               input logic [XLEN-1:0] wd, input logic dv, input logic [AW-1:0] da,
                               input logic [XLEN-1:0] dd, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; wb_we = we; wb_rd = rd; wb_data = wd;
    dbg_valid = dv; dbg_addr = da; dbg_data = dd;
    expq.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", tag, fld, act, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.tag, "rf_we",      XLEN'(rf_we),      XLEN'(e.we));
    cmp(e.tag, "rf_wa",      XLEN'(rf_wa),      XLEN'(e.wa));
    cmp(e.tag, "rf_wd",      rf_wd,             e.wd);
    cmp(e.tag, "dbg_ready",  XLEN'(dbg_ready),  XLEN'(e.rdy));
    cmp(e.tag, "pipe_stall", XLEN'(pipe_stall), XLEN'(e.stall));
    cmp(e.tag, "init_done",  XLEN'(init_done),  XLEN'(e.done));
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle against the
  // oldest queued expectation.
  always @(negedge clk) begin
    if (expq.size() > 0) checkOutput(expq.pop_front());
  end

  initial begin
    exp_t idle;
    exp_t wb3;
    idle = mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "idle");
    wb3  = mk(1'b1, AW'(3), 32'h33, 1'b0, 1'b0, 1'b1, "wb_x3");

    // Clear sequence with WB and debug requests active; both must be ignored.
    for (int i = 1; i < NUM_REGS; i++)
      applyStimulus(1'b0, 1'b1, AW'(9), 32'h9999, 1'b1, AW'(4), 32'h4444,
                    mk(1'b1, AW'(i), '0, 1'b0, 1'b1, 1'b0, $sformatf("clear%0d", i)));
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, idle);

    // WB beats debug to the same register, then debug is granted.
    applyStimulus(1'b0, 1'b1, AW'(5), 32'hDEADBEEF, 1'b1, AW'(5), 32'hA5A5,
                  mk(1'b1, AW'(5), 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, "wb_wins"));
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(5), 32'hA5A5,
                  mk(1'b1, AW'(5), 32'hA5A5, 1'b1, 1'b0, 1'b1, "dbg_retry"));
    // WB to x0 does not block debug.
    applyStimulus(1'b0, 1'b1, AW'(0), 32'h999, 1'b1, AW'(7), 32'h12,
                  mk(1'b1, AW'(7), 32'h12, 1'b1, 1'b0, 1'b1, "wb_x0_dbg"));
    // Debug write to x0 is accepted and dropped.
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(0), 32'h55,
                  mk(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "dbg_x0"));
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, idle);
    applyStimulus(1'b0, 1'b1, AW'(31), 32'h0BADF00D, 1'b0, '0, '0,
                  mk(1'b1, AW'(31), 32'h0BADF00D, 1'b0, 1'b0, 1'b1, "wb_x31"));
    applyStimulus(1'b0, 1'b1, AW'(0), 32'h77, 1'b0, '0, '0,
                  mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "wb_x0_only"));

    // Debug held against continuous WB traffic to x3.
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b1, AW'(3), 32'h33, 1'b1, AW'(9), 32'h99, wb3);
`ifdef RF_DBG_STARVE_GUARD_EN
    applyStimulus(1'b0, 1'b1, AW'(3), 32'h33, 1'b1, AW'(9), 32'h99,
                  mk(1'b1, AW'(9), 32'h99, 1'b1, 1'b1, 1'b1, "forced_dbg"));
`else
    applyStimulus(1'b0, 1'b1, AW'(3), 32'h33, 1'b1, AW'(9), 32'h99, wb3);
`endif
    applyStimulus(1'b0, 1'b1, AW'(3), 32'h33, 1'b0, '0, '0, wb3);

    // Reset during RUN: that cycle still shows RUN behaviour.
    applyStimulus(1'b1, 1'b1, AW'(6), 32'h66, 1'b0, '0, '0,
                  mk(1'b1, AW'(6), 32'h66, 1'b0, 1'b0, 1'b1, "rst_in_run"));
    for (int i = 1; i < 12; i++)
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0,
                    mk(1'b1, AW'(i), '0, 1'b0, 1'b1, 1'b0, $sformatf("reclear%0d", i)));
    // Reset again mid-clear at index 12; the sequence restarts from x1.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, AW'(2), 32'h22,
                  mk(1'b1, AW'(12), '0, 1'b0, 1'b1, 1'b0, "rst_at12"));
    for (int i = 1; i < NUM_REGS; i++)
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0,
                    mk(1'b1, AW'(i), '0, 1'b0, 1'b1, 1'b0, $sformatf("clear2_%0d", i)));
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(2), 32'h22,
                  mk(1'b1, AW'(2), 32'h22, 1'b1, 1'b0, 1'b1, "dbg_after_clear"));

    // Let the monitor drain, bounded.
    for (int i = 0; i < 4 && expq.size() > 0; i++) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
